// File: rtl/run_trace_sequencer_if.sv
// Handshake and trace bundle between the run controller and its host.
interface run_trace_sequencer_if #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 16
) ();
   logic                       start;
   logic [DATA_W-1:0]          bus;
   logic                       core_resetn;
   logic                       running;
   logic                       done;
   logic                       timeout;
   logic [31:0]                cycle_count;
   logic                       rd_en;
   logic [DATA_W-1:0]          rd_data;
   logic                       rd_valid;
   logic [$clog2(DEPTH+1)-1:0] trace_count;
   logic                       overflow;

   modport master (
      output start, bus, rd_en,
      input  core_resetn, running, done, timeout, cycle_count,
      input  rd_data, rd_valid, trace_count, overflow
   );

   modport slave (
      input  start, bus, rd_en,
      output core_resetn, running, done, timeout, cycle_count,
      output rd_data, rd_valid, trace_count, overflow
   );
endinterface

// File: rtl/run_trace_sequencer.sv
// Core run controller: pulses core reset, runs until halt word or timeout, traces bus into a FIFO.
// Read latency 1 cycle; no backpressure on the bus side, captures into a full FIFO are dropped and flagged.
module run_trace_sequencer #(
   parameter int                DATA_W       = 16,
   parameter int                DEPTH        = 16,
   parameter int                RST_CYCLES   = 2,
   parameter int                TIMEOUT      = 64,
   parameter logic [DATA_W-1:0] HALT_WORD    = 16'hFFFF,
   parameter int                HALT_HOLD    = 2,
   parameter int                CAPTURE_MODE = 1
) (
   input logic                 clock,
   input logic                 resetn,
   run_trace_sequencer_if.slave io
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int RC_W  = $clog2(RST_CYCLES+1);
   localparam int HC_W  = $clog2(HALT_HOLD+1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_RST_CORE, S_RUN, S_DONE, S_TIMEOUT} state_e;

   state_e            state_q, state_d;
   logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
   logic [31:0]       cycle_q, cycle_d;
   logic [HC_W-1:0]   halt_q, halt_d;
   logic              first_q, first_d;
   logic [DATA_W-1:0] last_q, last_d;
   logic              clear, push;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] rd_data_q;
   logic              rd_valid_q, overflow_q;
   logic              pop, full, wr_ok, drop;

   always_comb begin
      state_d   = state_q;
      rst_cnt_d = rst_cnt_q;
      cycle_d   = cycle_q;
      halt_d    = halt_q;
      first_d   = first_q;
      last_d    = last_q;
      clear     = 1'b0;
      push      = 1'b0;
      case (state_q)
         S_IDLE, S_DONE, S_TIMEOUT: begin
            if (io.start) begin
               state_d   = S_RST_CORE;
               rst_cnt_d = '0;
               cycle_d   = '0;
               halt_d    = '0;
               first_d   = 1'b1;
               clear     = 1'b1;
            end
         end
         S_RST_CORE: begin
            if (rst_cnt_q == RC_W'(RST_CYCLES-1)) state_d = S_RUN;
            else                                   rst_cnt_d = rst_cnt_q + 1'b1;
         end
         S_RUN: begin
            cycle_d = (cycle_q == 32'hFFFF_FFFF) ? cycle_q : cycle_q + 32'd1;
            halt_d  = (io.bus == HALT_WORD) ? halt_q + 1'b1 : '0;
            push    = (CAPTURE_MODE == 0) || first_q || (io.bus != last_q);
            first_d = 1'b0;
            if (push) last_d = io.bus;
            // Halt is checked first so it wins over a coincident timeout.
            if (halt_d >= HC_W'(HALT_HOLD))  state_d = S_DONE;
            else if (cycle_d >= 32'(TIMEOUT)) state_d = S_TIMEOUT;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      full    = (count_q == DEPTH_C);
      pop     = io.rd_en && (count_q != '0) && !clear;
      wr_ok   = push && (!full || pop);
      drop    = push && !wr_ok;
      count_d = clear ? '0 : count_q + CNT_W'(wr_ok) - CNT_W'(pop);
   end

   always_ff @(posedge clock or posedge resetn) begin
      if (resetn) begin
         state_q    <= S_IDLE;
         rst_cnt_q  <= '0;
         cycle_q    <= '0;
         halt_q     <= '0;
         first_q    <= 1'b0;
         last_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rst_cnt_q  <= rst_cnt_d;
         cycle_q    <= cycle_d;
         halt_q     <= halt_d;
         first_q    <= first_d;
         last_q     <= last_d;
         count_q    <= count_d;
         rd_valid_q <= pop;
         if (pop) rd_data_q <= mem_q[rd_ptr_q];
         if (clear) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
         end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            if (drop)  overflow_q <= 1'b1;
         end
      end
   end

   // When full, push and pop hit the same slot; the read sees the old word.
   always_ff @(posedge clock) begin
      if (wr_ok) mem_q[wr_ptr_q] <= io.bus;
   end

   assign io.core_resetn = (state_q != S_RUN);
   assign io.running     = (state_q == S_RUN);
   assign io.done        = (state_q == S_DONE);
   assign io.timeout     = (state_q == S_TIMEOUT);
   assign io.cycle_count = cycle_q;
   assign io.rd_data     = rd_data_q;
   assign io.rd_valid    = rd_valid_q;
   assign io.trace_count = count_q;
   assign io.overflow    = overflow_q;
endmodule

// File: tb/tb_run_trace_sequencer.sv
// Directed bench: two sequencer instances (change-capture and capture-every-cycle) on shared stimulus.
module tb_run_trace_sequencer;
   logic        clock = 1'b0;
   logic        resetn;
   logic        start;
   logic [15:0] bus;
   logic        rd_en;
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clock = ~clock;

   run_trace_sequencer_if #(.DATA_W(16), .DEPTH(16)) if1 ();
   run_trace_sequencer_if #(.DATA_W(16), .DEPTH(16)) if0 ();

   assign if1.start = start;
   assign if1.bus   = bus;
   assign if1.rd_en = rd_en;
   assign if0.start = start;
   assign if0.bus   = bus;
   assign if0.rd_en = rd_en;

   run_trace_sequencer #(.CAPTURE_MODE(1)) u_dut1 (.clock(clock), .resetn(resetn), .io(if1));
   run_trace_sequencer #(.CAPTURE_MODE(0)) u_dut0 (.clock(clock), .resetn(resetn), .io(if0));

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic start_run();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
   endtask

   task automatic pop();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   initial begin
      resetn = 1'b1;
      start  = 1'b0;
      bus    = 16'h0000;
      rd_en  = 1'b0;
      #3;
      // Test 1: reset state, then idle without start
      check_eq("rst_core_resetn", 32'(if1.core_resetn), 32'd1);
      check_eq("rst_running",     32'(if1.running),     32'd0);
      check_eq("rst_rd_data",     32'(if1.rd_data),     32'd0);
      check_eq("rst_trace_count", 32'(if1.trace_count), 32'd0);
      #4 resetn = 1'b0;
      repeat (5) tick();
      check_eq("idle_core_resetn", 32'(if1.core_resetn), 32'd1);
      check_eq("idle_running",     32'(if1.running),     32'd0);
      check_eq("idle_trace_count", 32'(if1.trace_count), 32'd0);
      check_eq("idle_cycle_count", 32'(if1.cycle_count), 32'd0);

      // Test 2: short program ending on the halt word
      start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("t2_rst1_core_resetn", 32'(if1.core_resetn), 32'd1);
      check_eq("t2_rst1_running",     32'(if1.running),     32'd0);
      tick();
      check_eq("t2_rst2_core_resetn", 32'(if1.core_resetn), 32'd1);
      tick();
      check_eq("t2_run_core_resetn",  32'(if1.core_resetn), 32'd0);
      check_eq("t2_run_running",      32'(if1.running),     32'd1);
      bus = 16'h0001; tick();
      bus = 16'h0002; tick();
      bus = 16'h0003; tick();
      bus = 16'hFFFF; tick();
      check_eq("t2_one_halt_done", 32'(if1.done), 32'd0);
      tick();
      check_eq("t2_done",         32'(if1.done),        32'd1);
      check_eq("t2_running",      32'(if1.running),     32'd0);
      check_eq("t2_core_resetn",  32'(if1.core_resetn), 32'd1);
      check_eq("t2_cycle_count",  if1.cycle_count,      32'd5);
      check_eq("t2_trace_count",  32'(if1.trace_count), 32'd4);
      check_eq("t2_m0_count",     32'(if0.trace_count), 32'd5);
      begin
         logic [15:0] exp2 [4] = '{16'h0001, 16'h0002, 16'h0003, 16'hFFFF};
         for (int i = 0; i < 4; i++) begin
            pop();
            check_eq($sformatf("t2_pop%0d_valid", i), 32'(if1.rd_valid), 32'd1);
            check_eq($sformatf("t2_pop%0d_data", i),  32'(if1.rd_data),  32'(exp2[i]));
         end
      end
      tick();
      check_eq("t2_valid_pulse", 32'(if1.rd_valid), 32'd0);

      // Test 3: constant bus runs into timeout; start mid-run is ignored
      bus = 16'h0005;
      start_run();
      for (int i = 1; i <= 63; i++) begin
         start = (i == 10);
         tick();
      end
      start = 1'b0;
      check_eq("t3_pre_running", 32'(if1.running),  32'd1);
      check_eq("t3_pre_timeout", 32'(if1.timeout),  32'd0);
      check_eq("t3_pre_cycles",  if1.cycle_count,   32'd63);
      tick();
      check_eq("t3_timeout",     32'(if1.timeout),     32'd1);
      check_eq("t3_done",        32'(if1.done),        32'd0);
      check_eq("t3_running",     32'(if1.running),     32'd0);
      check_eq("t3_cycles",      if1.cycle_count,      32'd64);
      check_eq("t3_trace_count", 32'(if1.trace_count), 32'd1);
      repeat (3) tick();
      check_eq("t3_timeout_sticky", 32'(if1.timeout), 32'd1);
      pop();
      check_eq("t3_pop_data", 32'(if1.rd_data), 32'h0005);

      // Test 4: capture-every-cycle instance overflows after 16 words
      start_run();
      for (int i = 0; i < 20; i++) begin
         bus = 16'h0100 + 16'(i);
         tick();
      end
      check_eq("t4_count",    32'(if0.trace_count), 32'd16);
      check_eq("t4_overflow", 32'(if0.overflow),    32'd1);
      check_eq("t4_cycles",   if0.cycle_count,      32'd20);
      bus = 16'hFFFF; tick(); tick();
      check_eq("t4_done", 32'(if0.done), 32'd1);
      for (int i = 0; i < 16; i++) begin
         pop();
         check_eq($sformatf("t4_pop%0d_valid", i), 32'(if0.rd_valid), 32'd1);
         check_eq($sformatf("t4_pop%0d_data", i),  32'(if0.rd_data),  32'h0100 + i);
      end
      check_eq("t4_m1_last_data", 32'(if1.rd_data), 32'h010F);
      pop();
      check_eq("t4_empty_valid", 32'(if0.rd_valid),    32'd0);
      check_eq("t4_empty_hold",  32'(if0.rd_data),     32'h010F);
      check_eq("t4_empty_count", 32'(if0.trace_count), 32'd0);

      // Test 5: push and pop together while full
      start_run();
      check_eq("t5_restart_overflow", 32'(if0.overflow), 32'd0);
      for (int i = 0; i < 16; i++) begin
         bus = 16'h0300 + 16'(i);
         tick();
      end
      check_eq("t5_full_count",    32'(if0.trace_count), 32'd16);
      check_eq("t5_full_overflow", 32'(if0.overflow),    32'd0);
      bus   = 16'h0310;
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check_eq("t5_both_count",    32'(if0.trace_count), 32'd16);
      check_eq("t5_both_overflow", 32'(if0.overflow),    32'd0);
      check_eq("t5_both_valid",    32'(if0.rd_valid),    32'd1);
      check_eq("t5_both_data",     32'(if0.rd_data),     32'h0300);
      bus = 16'hFFFF; tick(); tick();
      check_eq("t5_done", 32'(if0.done), 32'd1);
      for (int i = 0; i < 16; i++) begin
         pop();
         check_eq($sformatf("t5_pop%0d_data", i), 32'(if0.rd_data), 32'h0301 + i);
      end

      // Test 6: reset mid-run, then a fresh run
      bus = 16'h00A0;
      start_run();
      bus = 16'h00A1; tick();
      bus = 16'h00A2; tick();
      bus = 16'h00A3; tick();
      check_eq("t6_pre_count", 32'(if1.trace_count), 32'd3);
      resetn = 1'b1;
      #1;
      check_eq("t6_rst_running",     32'(if1.running),     32'd0);
      check_eq("t6_rst_core_resetn", 32'(if1.core_resetn), 32'd1);
      check_eq("t6_rst_count",       32'(if1.trace_count), 32'd0);
      check_eq("t6_rst_cycles",      if1.cycle_count,      32'd0);
      #2 resetn = 1'b0;
      tick();
      check_eq("t6_idle_running", 32'(if1.running), 32'd0);
      start_run();
      bus = 16'h00B1; tick();
      bus = 16'h00B2; tick();
      bus = 16'hFFFF; tick(); tick();
      check_eq("t6_done",   32'(if1.done),        32'd1);
      check_eq("t6_count",  32'(if1.trace_count), 32'd3);
      check_eq("t6_cycles", if1.cycle_count,      32'd4);
      begin
         logic [15:0] exp6 [3] = '{16'h00B1, 16'h00B2, 16'hFFFF};
         for (int i = 0; i < 3; i++) begin
            pop();
            check_eq($sformatf("t6_pop%0d_data", i), 32'(if1.rd_data), 32'(exp6[i]));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
